// File: rtl/reset_sequencer_if.sv
// Staged-reset bundle: raw user reset in, staged resets and status out.
// master = the sequencer, slave = the subsystems / host consuming it.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  user_reset;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  all_ready;
    logic                  seq_busy;
    logic [7:0]            restart_count;

    modport master (
        input  user_reset,
        output stage_reset, all_ready, seq_busy, restart_count
    );

    modport slave (
        output user_reset,
        input  stage_reset, all_ready, seq_busy, restart_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on / user reset sequencer: holds all stages, then releases them in
// index order with a fixed gap. A debounced user reset re-runs the sequence.
module reset_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int POR_CYCLES = 16,
    parameter int STAGE_GAP  = 8,
    parameter int DEBOUNCE   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    reset_sequencer_if.master   bus
);
    localparam int DW = $clog2(DEBOUNCE + 2);
    localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [1:0] {S_POR, S_REL, S_RUN, S_HOLD} state_t;

    // Declaration initialisers give the power-up state, so no reset pulse is needed.
    state_t                state   = S_POR;
    logic [CNT_W-1:0]      cnt     = '0;
    logic [KW-1:0]         k       = '0;
    logic [NUM_STAGES-1:0] stage_q = '1;
    logic                  ready_q = 1'b0;
    logic                  busy_q  = 1'b1;
    logic [7:0]            rcnt_q  = 8'd0;
    logic                  usr_meta = 1'b0;
    logic                  usr_s    = 1'b0;
    logic [DW-1:0]         dcnt     = '0;

    state_t                state_n;
    logic [CNT_W-1:0]      cnt_n;
    logic [KW-1:0]         k_n;
    logic [NUM_STAGES-1:0] stage_n;
    logic [7:0]            rcnt_n;
    logic                  accept;

    // Filter parks at DEBOUNCE+1 while held, so one press yields one accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            usr_meta <= 1'b0;
            usr_s    <= 1'b0;
            dcnt     <= '0;
        end else begin
            usr_meta <= bus.user_reset;
            usr_s    <= usr_meta;
            if (!usr_s)
                dcnt <= '0;
            else if (dcnt <= DW'(DEBOUNCE))
                dcnt <= dcnt + 1'b1;
        end
    end

    assign accept = (dcnt == DW'(DEBOUNCE)) && (state != S_HOLD);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k;
        stage_n = stage_q;
        rcnt_n  = rcnt_q;
        unique case (state)
            S_POR: begin
                stage_n = '1;
                if (cnt == CNT_W'(POR_CYCLES)) begin
                    state_n    = S_REL;
                    cnt_n      = '0;
                    k_n        = '0;
                    stage_n[0] = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_REL: begin
                if (k == KW'(NUM_STAGES - 1)) begin
                    state_n = S_RUN;
                end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                    cnt_n          = '0;
                    k_n            = k + 1'b1;
                    stage_n[k_n]   = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RUN: stage_n = '0;
            S_HOLD: begin
                stage_n = '1;
                if (!usr_s) begin
                    state_n = S_POR;
                    cnt_n   = '0;
                end
            end
        endcase
        if (accept) begin
            state_n = S_HOLD;
            stage_n = '1;
            cnt_n   = '0;
            if (rcnt_q != 8'hFF)
                rcnt_n = rcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_POR;
            cnt     <= '0;
            k       <= '0;
            stage_q <= '1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            rcnt_q  <= 8'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            k       <= k_n;
            stage_q <= stage_n;
            ready_q <= (state_n == S_RUN);
            busy_q  <= (state_n != S_RUN);
            rcnt_q  <= rcnt_n;
        end
    end

    assign bus.stage_reset   = stage_q;
    assign bus.all_ready     = ready_q;
    assign bus.seq_busy      = busy_q;
    assign bus.restart_count = rcnt_q;
endmodule
